// File: rtl/pll_rst_seq.sv
// Reset sequencer behind the clock wizard: holds the PLL in reset, waits for a stable lock and then releases core -> periph -> io.
// Define PLL_RST_SEQ_TIMEOUT_EN to re-pulse the PLL when WAIT_LOCK runs for LOCK_TIMEOUT cycles without lock.
module pll_rst_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 1000,
  parameter int STAGE_GAP      = 16,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int CNT_W          = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             locked,
  output logic             pll_rst,
  output logic             rst_n_core,
  output logic             rst_n_periph,
  output logic             rst_n_io,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int MAX_LD = max4(PLL_RST_CYCLES, STABLE_CYCLES, STAGE_GAP, LOCK_TIMEOUT);
  localparam int CW     = $clog2(MAX_LD + 1);

  // A state loaded with N-1 on entry lasts N cycles; the count hits zero on its last cycle.
  localparam logic [CW-1:0] LD_PLL    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LD_STABLE = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LD_GAP    = CW'(STAGE_GAP - 1);
  // Out of reset the first edge counts as the PLL_RST entry, so the pulse spans PLL_RST_CYCLES edges after it.
  localparam logic [CW-1:0] LD_PWR    = CW'(PLL_RST_CYCLES);
`ifdef PLL_RST_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] LD_WAIT   = CW'(LOCK_TIMEOUT - 1);
`else
  localparam logic [CW-1:0] LD_WAIT   = '0;
`endif

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_REL0      = 3'd3,
    S_REL1      = 3'd4,
    S_RUN       = 3'd5
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   w_loss_in_run;
  logic                   r_pll_rst;
  logic                   r_rst_n_core;
  logic                   r_rst_n_periph;
  logic                   r_rst_n_io;
  logic                   r_ready;
  logic [CNT_W-1:0]       r_loss_cnt;
  logic                   w_pll_rst_nxt;
  logic                   w_core_nxt;
  logic                   w_periph_nxt;
  logic                   w_io_nxt;
  logic                   w_ready_nxt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_PLL_RST;
      r_cnt   <= LD_PWR;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
    w_loss_in_run = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = LD_WAIT;
        end
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = S_STABLE;
          w_cnt_nxt   = LD_STABLE;
        end
`ifdef PLL_RST_SEQ_TIMEOUT_EN
        else if (r_cnt == '0) begin
          w_state_nxt = S_PLL_RST;
          w_cnt_nxt   = LD_PLL;
        end
`endif
      end
      S_STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = LD_WAIT;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_REL0;
          w_cnt_nxt   = LD_GAP;
        end
      end
      S_REL0: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = LD_WAIT;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_REL1;
          w_cnt_nxt   = LD_GAP;
        end
      end
      S_REL1: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = LD_WAIT;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt   = S_WAIT_LOCK;
          w_cnt_nxt     = LD_WAIT;
          w_loss_in_run = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_PLL_RST;
        w_cnt_nxt   = LD_PLL;
      end
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state and leave from flops.
  always_comb begin
    w_pll_rst_nxt = (w_state_nxt == S_PLL_RST);
    w_core_nxt    = (w_state_nxt == S_REL0) || (w_state_nxt == S_REL1) || (w_state_nxt == S_RUN);
    w_periph_nxt  = (w_state_nxt == S_REL1) || (w_state_nxt == S_RUN);
    w_io_nxt      = (w_state_nxt == S_RUN);
    w_ready_nxt   = (w_state_nxt == S_RUN);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pll_rst      <= 1'b1;
      r_rst_n_core   <= 1'b0;
      r_rst_n_periph <= 1'b0;
      r_rst_n_io     <= 1'b0;
      r_ready        <= 1'b0;
      r_loss_cnt     <= '0;
    end else begin
      r_pll_rst      <= w_pll_rst_nxt;
      r_rst_n_core   <= w_core_nxt;
      r_rst_n_periph <= w_periph_nxt;
      r_rst_n_io     <= w_io_nxt;
      r_ready        <= w_ready_nxt;
      if (w_loss_in_run) r_loss_cnt <= sat_inc(r_loss_cnt);
    end
  end

  assign pll_rst       = r_pll_rst;
  assign rst_n_core    = r_rst_n_core;
  assign rst_n_periph  = r_rst_n_periph;
  assign rst_n_io      = r_rst_n_io;
  assign ready         = r_ready;
  assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq: power-up pulse, staged release, glitch restart, loss counting, timeout and async reset.
module tb_pll_rst_seq;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       locked;
  logic       pll_rst;
  logic       rst_n_core;
  logic       rst_n_periph;
  logic       rst_n_io;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  int checks;
  int errors;
  int n;

  pll_rst_seq #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .STABLE_CYCLES (8),
    .STAGE_GAP     (4),
    .LOCK_TIMEOUT  (32),
    .CNT_W         (8)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .locked       (locked),
    .pll_rst      (pll_rst),
    .rst_n_core   (rst_n_core),
    .rst_n_periph (rst_n_periph),
    .rst_n_io     (rst_n_io),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return pll_rst;
      1:       return rst_n_core;
      2:       return rst_n_periph;
      3:       return rst_n_io;
      default: return ready;
    endcase
  endfunction

  task automatic step(input int k);
    repeat (k) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Edges until the selected output reaches v; -1 when the bound expires first.
  task automatic cnt_edges(input int w, input logic v, input int maxn, output int cnt);
    cnt = -1;
    for (int i = 1; i <= maxn; i++) begin
      @(posedge sys_clk);
      #1;
      if (sig(w) === v) begin
        cnt = i;
        break;
      end
    end
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, pll_rst, rst_n_core, rst_n_periph, rst_n_io, ready};
  endfunction

  initial begin
    checks    = 0;
    errors    = 0;
    sys_rst_n = 1'b0;
    locked    = 1'b0;
    #12;
    check("reset_outs", outs(), 32'b10000);
    check("reset_cnt", {24'd0, lock_loss_cnt}, 32'd0);

    // Power-up: pulse covers edges 1..4 after release, drops on edge 5
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check("pwr_pll_hi", outs(), 32'b10000);
    end
    step(1);
    check("pwr_pll_fall", outs(), 32'b00000);

`ifdef PLL_RST_SEQ_TIMEOUT_EN
    cnt_edges(0, 1'b1, 40, n);
    check("to_rise1", n, 32);
    cnt_edges(0, 1'b0, 10, n);
    check("to_len1", n, 4);
    cnt_edges(0, 1'b1, 40, n);
    check("to_rise2", n, 32);
    cnt_edges(0, 1'b0, 10, n);
    check("to_len2", n, 4);
`else
    cnt_edges(0, 1'b1, 80, n);
    check("no_timeout", n, -1);
`endif

    // Clean lock
    locked = 1'b1;
    cnt_edges(1, 1'b1, 30, n);
    check("lock_core", n, 11);
    check("lock_core_only", outs(), 32'b01000);
    cnt_edges(2, 1'b1, 10, n);
    check("lock_periph", n, 4);
    check("lock_periph_io0", rst_n_io, 1'b0);
    cnt_edges(3, 1'b1, 10, n);
    check("lock_io", n, 4);
    check("lock_run_outs", outs(), 32'b01111);
    check("lock_cnt0", {24'd0, lock_loss_cnt}, 32'd0);

    // Loss in RUN
    locked = 1'b0;
    cnt_edges(1, 1'b0, 10, n);
    check("loss_core", n, 3);
    check("loss_all_low", outs(), 32'b00000);
    check("loss_cnt1", {24'd0, lock_loss_cnt}, 32'd1);

    // Single-cycle glitch five cycles into STABLE restarts the window
    locked = 1'b1;
    step(5);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    cnt_edges(1, 1'b1, 30, n);
    check("glitch_core", n, 11);
    cnt_edges(4, 1'b1, 20, n);
    check("glitch_ready", n, 8);

    // Repeated losses drive the counter into saturation
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      cnt_edges(1, 1'b0, 10, n);
      check("sat_loss", n, 3);
      check("sat_cnt", {24'd0, lock_loss_cnt}, (i + 2 > 255) ? 32'd255 : 32'(i + 2));
      locked = 1'b1;
      cnt_edges(4, 1'b1, 40, n);
      check("sat_relock", n, 19);
    end
    check("sat_final", {24'd0, lock_loss_cnt}, 32'd255);

    // Async reset in the middle of REL1
    locked = 1'b0;
    cnt_edges(1, 1'b0, 10, n);
    check("pre_rst_loss", n, 3);
    locked = 1'b1;
    cnt_edges(1, 1'b1, 30, n);
    check("pre_rst_core", n, 11);
    step(5);
    check("rel1_outs", outs(), 32'b01100);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("async_outs", outs(), 32'b10000);
    check("async_cnt", {24'd0, lock_loss_cnt}, 32'd0);

    // Release with lock already present, then lose it in REL0: no count
    sys_rst_n = 1'b1;
    cnt_edges(1, 1'b1, 30, n);
    check("rerel_core", n, 14);
    locked = 1'b0;
    cnt_edges(1, 1'b0, 10, n);
    check("rel0_loss", n, 3);
    check("rel0_loss_outs", outs(), 32'b00000);
    check("rel0_nocount", {24'd0, lock_loss_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
